// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, init FSM states, phase map and address helpers.
// No logic and no latency; backpressure does not apply.
package sdram_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PRE   = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    // CL2, sequential, burst length 1
    localparam logic [12:0] MODE_REG = 13'h020;
    localparam logic [12:0] A10_BIT  = 13'h400;

    localparam int          CAS_LAT   = 2;
    localparam logic [2:0]  ACT_PHASE = 3'd0;
    localparam logic [2:0]  CMD_PHASE = 3'd2;
    localparam logic [2:0]  CAP_PHASE = 3'(int'(CMD_PHASE) + CAS_LAT);

    typedef enum logic [2:0] {
        ST_INIT_WAIT,
        ST_INIT_PRE,
        ST_INIT_REF1,
        ST_INIT_REF2,
        ST_INIT_MRS,
        ST_RUN
    } state_t;

    typedef struct packed {
        logic [1:0]  ba;
        logic [8:0]  col;
        logic [15:0] din;
        logic [1:0]  ds;
        logic        wr;
    } req_t;

    function automatic logic [12:0] row_of(input logic [20:0] addr);
        return {3'b000, addr[20:11]};
    endfunction

    function automatic logic [12:0] col_of(input logic [8:0] col);
        return {4'b0000, col};
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer with a single sticky pending flag.
// Pending rises one clock after the interval expires; clears on clr.
// No backpressure: repeated expiries while pending collapse into one flag.
module sdram_refresh_timer #(
    parameter int REFRESH_INTERVAL = 500
) (
    input  logic clk_sys,
    input  logic RESET,
    input  logic en,
    input  logic clr,
    output logic ref_pend
);

    localparam int CNT_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    logic [CNT_W-1:0] cnt;
    logic             expire;

    assign expire = (cnt == CNT_W'(REFRESH_INTERVAL - 1));

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            cnt      <= '0;
            ref_pend <= 1'b0;
        end else begin
            if (en) begin
                cnt <= expire ? '0 : cnt + 1'b1;
            end
            // a fresh expiry wins over a same-cycle clear so no interval is lost
            if (en && expire) begin
                ref_pend <= 1'b1;
            end else if (clr) begin
                ref_pend <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sdram_phase_ctrl.sv
// Phase-locked SDRAM controller: init sequence, one access per 8-phase cycle, auto refresh.
// Commands registered (visible after the deciding edge); read data captured at CAP_PHASE.
// No backpressure: a request at ACT_PHASE is always accepted once init is done.
module sdram_phase_ctrl
    import sdram_pkg::*;
#(
    parameter int INIT_WAIT        = 6400,
    parameter int REFRESH_INTERVAL = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  busPhase,
    input  logic [20:0] ram_addr,
    input  logic [15:0] ram_din,
    input  logic [1:0]  ram_ds,
    input  logic        ram_we,
    input  logic        ram_oe,
    output logic [15:0] ram_dout,
    output logic        init_done,
    output logic        sd_cke,
    output logic        sd_cs_n,
    output logic        sd_ras_n,
    output logic        sd_cas_n,
    output logic        sd_we_n,
    output logic [1:0]  sd_ba,
    output logic [12:0] sd_addr,
    output logic [1:0]  sd_dqm,
    output logic [15:0] sd_dq_o,
    output logic        sd_dq_oe,
    input  logic [15:0] sd_dq_i
);

    state_t      st_q, st_nxt;
    logic [15:0] wait_cnt;
    logic        wait_done;
    req_t        req_q;
    logic        acc_vld_q;
    logic        rd_vld_q;
    logic        ref_pend;
    logic        ref_clr;
    logic        req_ld;
    logic        acc_issue;
    logic        at_act;

    logic [3:0]  cmd_q, cmd_nxt;
    logic [1:0]  ba_nxt;
    logic [12:0] addr_nxt;
    logic [1:0]  dqm_nxt;
    logic [15:0] dq_o_nxt;
    logic        dq_oe_nxt;

    assign wait_done = (wait_cnt == 16'(INIT_WAIT - 1));
    assign at_act    = (busPhase == ACT_PHASE);

    sdram_refresh_timer #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL)
    ) u_refresh_timer (
        .clk_sys  (clk),
        .RESET    (reset),
        .en       (st_q == ST_RUN),
        .clr      (ref_clr),
        .ref_pend (ref_pend)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q <= ST_INIT_WAIT;
        end else begin
            st_q <= st_nxt;
        end
    end

    always_comb begin
        st_nxt    = st_q;
        cmd_nxt   = CMD_NOP;
        ba_nxt    = 2'b00;
        addr_nxt  = 13'h0000;
        dqm_nxt   = 2'b11;
        dq_o_nxt  = 16'h0000;
        dq_oe_nxt = 1'b0;
        req_ld    = 1'b0;
        acc_issue = 1'b0;
        ref_clr   = 1'b0;
        unique case (st_q)
            ST_INIT_WAIT: begin
                if (wait_done) st_nxt = ST_INIT_PRE;
            end
            ST_INIT_PRE: begin
                if (at_act) begin
                    cmd_nxt  = CMD_PRE;
                    addr_nxt = A10_BIT;
                    st_nxt   = ST_INIT_REF1;
                end
            end
            ST_INIT_REF1: begin
                if (at_act) begin
                    cmd_nxt = CMD_REF;
                    st_nxt  = ST_INIT_REF2;
                end
            end
            ST_INIT_REF2: begin
                if (at_act) begin
                    cmd_nxt = CMD_REF;
                    st_nxt  = ST_INIT_MRS;
                end
            end
            ST_INIT_MRS: begin
                if (at_act) begin
                    cmd_nxt  = CMD_MRS;
                    addr_nxt = MODE_REG;
                    st_nxt   = ST_RUN;
                end
            end
            ST_RUN: begin
                if (at_act) begin
                    if (ram_we || ram_oe) begin
                        req_ld   = 1'b1;
                        cmd_nxt  = CMD_ACT;
                        ba_nxt   = ram_addr[10:9];
                        addr_nxt = row_of(ram_addr);
                    end else if (ref_pend) begin
                        cmd_nxt = CMD_REF;
                        ref_clr = 1'b1;
                    end
                end else if (busPhase == CMD_PHASE && acc_vld_q) begin
                    acc_issue = 1'b1;
                    ba_nxt    = req_q.ba;
                    addr_nxt  = col_of(req_q.col) | A10_BIT;
                    if (req_q.wr) begin
                        cmd_nxt   = CMD_WRITE;
                        dq_o_nxt  = req_q.din;
                        dq_oe_nxt = 1'b1;
                        dqm_nxt   = ~req_q.ds;
                    end else begin
                        cmd_nxt = CMD_READ;
                        dqm_nxt = 2'b00;
                    end
                end else if (rd_vld_q) begin
                    // keep both lanes unmasked until read data is captured
                    dqm_nxt = 2'b00;
                end
            end
            default: st_nxt = ST_INIT_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt  <= 16'h0000;
            req_q     <= '0;
            acc_vld_q <= 1'b0;
            rd_vld_q  <= 1'b0;
            ram_dout  <= 16'h0000;
            cmd_q     <= CMD_NOP;
            sd_ba     <= 2'b00;
            sd_addr   <= 13'h0000;
            sd_dqm    <= 2'b11;
            sd_dq_o   <= 16'h0000;
            sd_dq_oe  <= 1'b0;
        end else begin
            if (st_q == ST_INIT_WAIT && !wait_done) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (req_ld) begin
                req_q     <= '{ba: ram_addr[10:9], col: ram_addr[8:0], din: ram_din,
                               ds: ram_ds, wr: ram_we};
                acc_vld_q <= 1'b1;
            end else if (acc_issue) begin
                acc_vld_q <= 1'b0;
            end
            if (acc_issue && !req_q.wr) begin
                rd_vld_q <= 1'b1;
            end else if (rd_vld_q && busPhase == CAP_PHASE) begin
                rd_vld_q <= 1'b0;
                ram_dout <= sd_dq_i;
            end
            cmd_q    <= cmd_nxt;
            sd_ba    <= ba_nxt;
            sd_addr  <= addr_nxt;
            sd_dqm   <= dqm_nxt;
            sd_dq_o  <= dq_o_nxt;
            sd_dq_oe <= dq_oe_nxt;
        end
    end

    assign {sd_cs_n, sd_ras_n, sd_cas_n, sd_we_n} = cmd_q;
    assign sd_cke    = 1'b1;
    assign init_done = (st_q == ST_RUN);

endmodule
